rtc_port_responder: RTL and testbench
=====================================

Name: rtc_port_responder

Overview:
- Peripheral-side responder on the PicoBlaze port bus. It is the other end of the bus that the micro drives: out_port, dir, writestrobe, read_strobe and the decoded actRTC select.
- It turns micro port writes into timed read/write cycles on the RTC chip's multiplexed address/data bus.
- It returns the address register, read data and status to the micro on in_portRTC.
- It sits between the micro and the top-level RTC pins. The top level owns the tristate buffer.

Parameters:
- T_SETUP, 2: clk cycles of setup before each strobe (1..255).
- T_STROBE, 4: clk cycles each rd/wr strobe is held low (1..255).
- T_HOLD, 2: clk cycles of hold after each strobe (1..255).

Ports:
- clk  in  1  system clock
- kcpsm6_reset  in  1  synchronous, active-high reset
- out_port  in  8  write data from micro
- dir  in  8  port_id from micro; only dir[1:0] is decoded
- writestrobe  in  1  micro write strobe, 1 clk pulse
- read_strobe  in  1  micro read strobe, 1 clk pulse
- actRTC  in  1  decoded select for this block
- in_portRTC  out  8  registered read-back data to micro
- busy  out  1  bus transaction in progress
- rtc_ad_out  out  8  value driven onto the AD bus
- rtc_ad_oe  out  1  1 = top level drives rtc_ad_out onto the pins
- rtc_ad_in  in  8  AD bus sampled from the pins
- rtc_cs_n  out  1  chip select, active low
- rtc_ad_sel  out  1  1 = address phase, 0 = data phase
- rtc_wr_n  out  1  write strobe, active low
- rtc_rd_n  out  1  read strobe, active low

Behaviour:
- Clock and reset: single clock domain, all state updated on posedge clk. Reset is synchronous and active-high: kcpsm6_reset sampled high on a posedge resets the block.
- Reset values:
  - in_portRTC = 0, busy = 0, rtc_ad_out = 0, rtc_ad_oe = 0
  - rtc_cs_n = 1, rtc_ad_sel = 1, rtc_wr_n = 1, rtc_rd_n = 1
  - addr_reg = 0, rd_data = 0, overrun = 0, FSM = IDLE
- Write decode, when writestrobe & actRTC, by dir[1:0]:
  - 0: addr_reg <= out_port.
  - 1: wdata <= out_port and start a WRITE.
  - 2: start a READ.
  - 3: ignored.
- Write decode while busy:
  - Offsets 1 and 2 are ignored and set overrun.
  - Offset 0 is also ignored and sets overrun; addr_reg is frozen during a transaction.
- Read-back: in_portRTC is registered every clk from dir[1:0], giving 1-cycle latency, which meets the KCPSM6 in_port timing.
  - 0 -> addr_reg
  - 1 -> rd_data
  - 2 -> rd_data
  - 3 -> {6'b0, overrun, busy}
- overrun is cleared on read_strobe & actRTC & dir[1:0]==3. If a new overrun and the clear coincide, set wins.
- Strobes with actRTC = 0 have no effect.
- FSM: IDLE -> A_SETUP -> A_STROBE -> A_HOLD -> D_SETUP -> D_STROBE -> D_HOLD -> IDLE.
  - One 8-bit down-counter is loaded with T_SETUP, T_STROBE or T_HOLD on entry to each state. The state advances when the counter reaches 1.
  - A start command accepted in IDLE enters A_SETUP on the next clk. busy = 1 from that edge until the FSM is back in IDLE.
  - A_*: cs_n = 0, ad_sel = 1, ad_oe = 1, ad_out = addr_reg. A_STROBE: wr_n = 0.
  - D_* for WRITE: cs_n = 0, ad_sel = 0, ad_oe = 1, ad_out = wdata. D_STROBE: wr_n = 0.
  - D_* for READ: cs_n = 0, ad_sel = 0, ad_oe = 0. D_STROBE: rd_n = 0. rd_data <= rtc_ad_in on the last D_STROBE cycle.
  - IDLE: cs_n = 1, ad_oe = 0, ad_sel = 1, rd_n = wr_n = 1.
- Transaction length: 2*(T_SETUP+T_STROBE+T_HOLD) clk, which is 16 with the defaults. rd_n and wr_n are never low together.
- Reset mid-transaction: on the next edge all strobes go high, oe goes 0 and the FSM returns to IDLE. No partial rd_data update.

Decomposition:
- Shared package (rtc_pkg): offset constants RTC_OFF_ADDR = 0, RTC_OFF_WDATA = 1, RTC_OFF_READ = 2, RTC_OFF_STAT = 3; the FSM state encoding; status bit positions.
- One natural sub-module: rtc_bus_timer, holding the FSM, the counter and the pin drivers. The top level keeps the port decode, registers and read-back mux.

Test Plan:
- Write addr 0x21, then WDATA 0x45 (defaults) -> rtc_ad_out = 0x21 with ad_sel = 1 and wr_n low for 4 clk; then 0x45 with ad_sel = 0 and wr_n low for 4 clk; busy high exactly 16 clk; rd_n stays 1.
- Addr 0x0C, READ, rtc_ad_in = 0x37 during D_STROBE -> ad_oe = 0 in the data phase, rd_n low for 4 clk; then dir = 1 read returns in_portRTC = 0x37 one clk after dir is set.
- WDATA 0x99 written while busy -> no second transaction, in-flight data unchanged; status read = 0x03 while busy, 0x02 after; cleared to 0x00 after a status read_strobe.
- kcpsm6_reset asserted in the 3rd A_STROBE cycle -> next edge: cs_n = wr_n = 1, oe = 0, busy = 0, addr_reg = 0, all outputs at reset values.
- writestrobe with actRTC = 0 and dir = 1 -> no bus activity, busy stays 0.
- T_SETUP = 1, T_STROBE = 1, T_HOLD = 1 -> 6-clk transaction, each strobe exactly 1 clk low.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC port responder: port offsets, status bit
// positions and the bus-cycle state encoding.
package rtc_pkg;

  localparam logic [1:0] RTC_OFF_ADDR  = 2'd0;
  localparam logic [1:0] RTC_OFF_WDATA = 2'd1;
  localparam logic [1:0] RTC_OFF_READ  = 2'd2;
  localparam logic [1:0] RTC_OFF_STAT  = 2'd3;

  localparam int RTC_STAT_BUSY_BIT = 0;
  localparam int RTC_STAT_OVR_BIT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_A_SETUP  = 3'd1,
    ST_A_STROBE = 3'd2,
    ST_A_HOLD   = 3'd3,
    ST_D_SETUP  = 3'd4,
    ST_D_STROBE = 3'd5,
    ST_D_HOLD   = 3'd6
  } rtc_state_e;

  // Fixed phase order of one bus cycle; anything unexpected falls back to idle.
  function automatic rtc_state_e rtc_next_state(input rtc_state_e s);
    case (s)
      ST_A_SETUP:  return ST_A_STROBE;
      ST_A_STROBE: return ST_A_HOLD;
      ST_A_HOLD:   return ST_D_SETUP;
      ST_D_SETUP:  return ST_D_STROBE;
      ST_D_STROBE: return ST_D_HOLD;
      ST_D_HOLD:   return ST_IDLE;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Sequencer for one multiplexed address/data cycle on the RTC bus.
// All pin drivers are registered and derived from the next state.
module rtc_bus_timer
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_wr_i,
  input  logic       start_rd_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       capture_o,
  output logic [7:0] ad_out_o,
  output logic       ad_oe_o,
  output logic       cs_n_o,
  output logic       ad_sel_o,
  output logic       wr_n_o,
  output logic       rd_n_o
);

  localparam logic [7:0] LD_SETUP  = 8'(T_SETUP);
  localparam logic [7:0] LD_STROBE = 8'(T_STROBE);
  localparam logic [7:0] LD_HOLD   = 8'(T_HOLD);

  rtc_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_read_q, is_read_d;
  logic       busy_q, busy_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_sel_q, ad_sel_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;

  function automatic logic [7:0] load_count(input rtc_state_e s);
    case (s)
      ST_A_SETUP, ST_D_SETUP:   load_count = LD_SETUP;
      ST_A_STROBE, ST_D_STROBE: load_count = LD_STROBE;
      ST_A_HOLD, ST_D_HOLD:     load_count = LD_HOLD;
      default:                  load_count = 8'd0;
    endcase
  endfunction

  // Next state: each phase lasts exactly its loaded count, advancing at count 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    case (state_q)
      ST_IDLE: begin
        if (start_wr_i || start_rd_i) begin
          state_d   = ST_A_SETUP;
          cnt_d     = LD_SETUP;
          is_read_d = start_rd_i;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD, ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        if (cnt_q == 8'd1) begin
          state_d = rtc_next_state(state_q);
          cnt_d   = load_count(rtc_next_state(state_q));
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Pin values for the state being entered, so they line up with the state register.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    cs_n_d   = 1'b1;
    ad_sel_d = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'd0;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    case (state_d)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_i;
        wr_n_d   = (state_d != ST_A_STROBE);
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        if (is_read_d) begin
          rd_n_d   = (state_d != ST_D_STROBE);
        end else begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_i;
          wr_n_d   = (state_d != ST_D_STROBE);
        end
      end
      default: begin
        cs_n_d   = 1'b1;
      end
    endcase
  end

  // State, counter and registered pin drivers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      is_read_q <= 1'b0;
      busy_q    <= 1'b0;
      ad_out_q  <= 8'd0;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      ad_sel_q  <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      busy_q    <= busy_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      cs_n_q    <= cs_n_d;
      ad_sel_q  <= ad_sel_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
    end
  end

  assign capture_o = (state_q == ST_D_STROBE) && (cnt_q == 8'd1) && is_read_q;
  assign busy_o    = busy_q;
  assign ad_out_o  = ad_out_q;
  assign ad_oe_o   = ad_oe_q;
  assign cs_n_o    = cs_n_q;
  assign ad_sel_o  = ad_sel_q;
  assign wr_n_o    = wr_n_q;
  assign rd_n_o    = rd_n_q;

endmodule

// File: rtl/rtc_port_responder.sv
// PicoBlaze port-bus responder for the RTC chip: decodes micro writes into
// bus cycles and returns address, read data and status on in_portRTC.
module rtc_port_responder
  import rtc_pkg::*;
#(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2
) (
  input  logic       clk,
  input  logic       kcpsm6_reset,
  input  logic [7:0] out_port,
  input  logic [7:0] dir,
  input  logic       writestrobe,
  input  logic       read_strobe,
  input  logic       actRTC,
  output logic [7:0] in_portRTC,
  output logic       busy,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in,
  output logic       rtc_cs_n,
  output logic       rtc_ad_sel,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n
);

  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       overrun_q, overrun_d;
  logic [7:0] in_port_q, in_port_d;

  logic       wr_hit_s, ovr_clr_s, ovr_set_s;
  logic       start_wr_s, start_rd_s;
  logic       busy_s, capture_s;
  logic [5:0] dir_unused_s;

  // Only the two offset bits select a register.
  assign dir_unused_s = dir[7:2];

  assign wr_hit_s  = writestrobe & actRTC;
  assign ovr_clr_s = read_strobe & actRTC & (dir[1:0] == RTC_OFF_STAT);

  // Port write decode; while a cycle is in flight every command is refused.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    start_wr_s = 1'b0;
    start_rd_s = 1'b0;
    ovr_set_s  = 1'b0;
    if (wr_hit_s) begin
      case (dir[1:0])
        RTC_OFF_ADDR: begin
          if (busy_s) ovr_set_s = 1'b1;
          else        addr_d    = out_port;
        end
        RTC_OFF_WDATA: begin
          if (busy_s) begin
            ovr_set_s  = 1'b1;
          end else begin
            wdata_d    = out_port;
            start_wr_s = 1'b1;
          end
        end
        RTC_OFF_READ: begin
          if (busy_s) ovr_set_s  = 1'b1;
          else        start_rd_s = 1'b1;
        end
        default: begin
          ovr_set_s = 1'b0;
        end
      endcase
    end else begin
      ovr_set_s = 1'b0;
    end
  end

  // Overrun flag (a new overrun beats a simultaneous clear) and read capture.
  always_comb begin
    if (ovr_set_s)      overrun_d = 1'b1;
    else if (ovr_clr_s) overrun_d = 1'b0;
    else                overrun_d = overrun_q;
    if (capture_s) rd_data_d = rtc_ad_in;
    else           rd_data_d = rd_data_q;
  end

  // Read-back mux, registered every clock.
  always_comb begin
    in_port_d = 8'd0;
    case (dir[1:0])
      RTC_OFF_ADDR:                in_port_d = addr_q;
      RTC_OFF_WDATA, RTC_OFF_READ: in_port_d = rd_data_q;
      RTC_OFF_STAT: begin
        in_port_d[RTC_STAT_OVR_BIT]  = overrun_q;
        in_port_d[RTC_STAT_BUSY_BIT] = busy_s;
      end
      default:                     in_port_d = 8'd0;
    endcase
  end

  // Host-visible registers.
  always_ff @(posedge clk) begin
    if (kcpsm6_reset) begin
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      rd_data_q <= 8'd0;
      overrun_q <= 1'b0;
      in_port_q <= 8'd0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      overrun_q <= overrun_d;
      in_port_q <= in_port_d;
    end
  end

  rtc_bus_timer #(
    .T_SETUP  (T_SETUP),
    .T_STROBE (T_STROBE),
    .T_HOLD   (T_HOLD)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (kcpsm6_reset),
    .start_wr_i (start_wr_s),
    .start_rd_i (start_rd_s),
    .addr_i     (addr_q),
    .wdata_i    (wdata_q),
    .busy_o     (busy_s),
    .capture_o  (capture_s),
    .ad_out_o   (rtc_ad_out),
    .ad_oe_o    (rtc_ad_oe),
    .cs_n_o     (rtc_cs_n),
    .ad_sel_o   (rtc_ad_sel),
    .wr_n_o     (rtc_wr_n),
    .rd_n_o     (rtc_rd_n)
  );

  assign busy       = busy_s;
  assign in_portRTC = in_port_q;

endmodule

// File: tb/tb_rtc_port_responder.sv
// Directed bench for rtc_port_responder: default-timing instance plus a
// minimum-timing instance sharing the micro-side bus.
module tb_rtc_port_responder;

  logic       clk;
  logic       kcpsm6_reset;
  logic [7:0] out_port;
  logic [7:0] dir;
  logic       writestrobe;
  logic       read_strobe;
  logic       actRTC;
  logic       actRTC2;
  logic [7:0] rtc_ad_in;

  logic [7:0] in_portRTC, rtc_ad_out;
  logic       busy, rtc_ad_oe, rtc_cs_n, rtc_ad_sel, rtc_wr_n, rtc_rd_n;
  logic [7:0] in_portRTC2, rtc_ad_out2;
  logic       busy2, rtc_ad_oe2, rtc_cs_n2, rtc_ad_sel2, rtc_wr_n2, rtc_rd_n2;

  int n_pass = 0;
  int n_total = 0;
  int m_busy, m_cs, m_awr, m_dwr, m_rd, m_both, m_bad;

  rtc_port_responder dut (
    .clk(clk), .kcpsm6_reset(kcpsm6_reset), .out_port(out_port), .dir(dir),
    .writestrobe(writestrobe), .read_strobe(read_strobe), .actRTC(actRTC),
    .in_portRTC(in_portRTC), .busy(busy), .rtc_ad_out(rtc_ad_out),
    .rtc_ad_oe(rtc_ad_oe), .rtc_ad_in(rtc_ad_in), .rtc_cs_n(rtc_cs_n),
    .rtc_ad_sel(rtc_ad_sel), .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n)
  );

  rtc_port_responder #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_min (
    .clk(clk), .kcpsm6_reset(kcpsm6_reset), .out_port(out_port), .dir(dir),
    .writestrobe(writestrobe), .read_strobe(read_strobe), .actRTC(actRTC2),
    .in_portRTC(in_portRTC2), .busy(busy2), .rtc_ad_out(rtc_ad_out2),
    .rtc_ad_oe(rtc_ad_oe2), .rtc_ad_in(rtc_ad_in), .rtc_cs_n(rtc_cs_n2),
    .rtc_ad_sel(rtc_ad_sel2), .rtc_wr_n(rtc_wr_n2), .rtc_rd_n(rtc_rd_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One micro port write; called and returns on a negedge.
  task automatic wr(input int sel, input logic [1:0] off, input logic [7:0] data);
    actRTC      = (sel == 0);
    actRTC2     = (sel == 1);
    dir         = {6'd0, off};
    out_port    = data;
    writestrobe = 1'b1;
    @(negedge clk);
    writestrobe = 1'b0;
  endtask

  // Watch the default-timing instance for n negedges, checking pin legality.
  task automatic mon(input int n, input logic [7:0] ea, input logic [7:0] ed, input bit is_rd);
    m_busy = 0; m_cs = 0; m_awr = 0; m_dwr = 0; m_rd = 0; m_both = 0; m_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) m_busy++;
      if (!rtc_cs_n) m_cs++;
      if (!rtc_wr_n && !rtc_rd_n) m_both++;
      if (!rtc_wr_n && rtc_ad_sel) m_awr++;
      if (!rtc_wr_n && !rtc_ad_sel) m_dwr++;
      if (!rtc_rd_n) m_rd++;
      if (!rtc_rd_n && rtc_ad_sel) m_bad++;
      if (!rtc_cs_n && rtc_ad_sel && (rtc_ad_out !== ea || rtc_ad_oe !== 1'b1)) m_bad++;
      if (!rtc_cs_n && !rtc_ad_sel) begin
        if (is_rd) begin
          if (rtc_ad_oe !== 1'b0) m_bad++;
        end else begin
          if (rtc_ad_out !== ed || rtc_ad_oe !== 1'b1) m_bad++;
        end
      end
      if (rtc_cs_n && rtc_ad_oe !== 1'b0) m_bad++;
      rtc_ad_in = !rtc_rd_n ? (8'h33 + 8'(m_rd)) : 8'hEE;
      @(negedge clk);
    end
  endtask

  initial begin
    int b2, a2n, d2n, a2i, d2i;
    logic [7:0] a2v, d2v;

    kcpsm6_reset = 1'b1;
    out_port = 8'd0; dir = 8'd0; writestrobe = 1'b0; read_strobe = 1'b0;
    actRTC = 1'b0; actRTC2 = 1'b0; rtc_ad_in = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    chk("reset_pins", {busy, rtc_ad_oe, rtc_cs_n, rtc_ad_sel, rtc_wr_n, rtc_rd_n}, 6'b001111);
    chk("reset_ad_out", rtc_ad_out, 8'h00);
    chk("reset_in_port", in_portRTC, 8'h00);
    chk("reset_min_pins", {busy2, rtc_ad_oe2, rtc_cs_n2}, 3'b001);
    kcpsm6_reset = 1'b0;
    @(negedge clk);

    // Write cycle: addr 0x21, data 0x45.
    wr(0, 2'd0, 8'h21);
    wr(0, 2'd1, 8'h45);
    chk("wr_first_busy", busy, 1'b1);
    chk("wr_first_ad_out", rtc_ad_out, 8'h21);
    mon(20, 8'h21, 8'h45, 1'b0);
    chk("wr_busy_cycles", m_busy, 16);
    chk("wr_cs_cycles", m_cs, 16);
    chk("wr_addr_strobe", m_awr, 4);
    chk("wr_data_strobe", m_dwr, 4);
    chk("wr_rd_n_low", m_rd, 0);
    chk("wr_bad_pins", m_bad, 0);

    // Read cycle: addr 0x0C, bus returns 0x37 on the last strobe cycle.
    wr(0, 2'd0, 8'h0C);
    wr(0, 2'd2, 8'h00);
    mon(20, 8'h0C, 8'h00, 1'b1);
    chk("rd_busy_cycles", m_busy, 16);
    chk("rd_rd_strobe", m_rd, 4);
    chk("rd_data_wr_n_low", m_dwr, 0);
    chk("rd_addr_strobe", m_awr, 4);
    chk("rd_both_low", m_both, 0);
    chk("rd_bad_pins", m_bad, 0);
    dir = 8'd3;
    @(negedge clk);
    chk("rd_status_idle", in_portRTC, 8'h00);
    dir = 8'd1;
    #1;
    chk("rd_latency_hold", in_portRTC, 8'h00);
    @(negedge clk);
    chk("rd_data_back", in_portRTC, 8'h37);
    dir = 8'd0;
    @(negedge clk);
    chk("rd_addr_back", in_portRTC, 8'h0C);

    // Overrun: data and address writes while busy are refused.
    wr(0, 2'd0, 8'h5A);
    wr(0, 2'd1, 8'hA5);
    wr(0, 2'd1, 8'h99);
    wr(0, 2'd0, 8'h77);
    dir = 8'd3;
    @(negedge clk);
    chk("ovr_status_busy", in_portRTC, 8'h03);
    chk("ovr_addr_inflight", rtc_ad_out, 8'h5A);
    mon(17, 8'h5A, 8'hA5, 1'b0);
    chk("ovr_busy_cycles", m_busy, 13);
    chk("ovr_data_strobe", m_dwr, 4);
    chk("ovr_bad_pins", m_bad, 0);
    chk("ovr_status_idle", in_portRTC, 8'h02);
    actRTC = 1'b1;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    chk("ovr_status_pre_clear", in_portRTC, 8'h02);
    @(negedge clk);
    chk("ovr_status_cleared", in_portRTC, 8'h00);
    dir = 8'd0;
    @(negedge clk);
    chk("ovr_addr_frozen", in_portRTC, 8'h5A);

    // Deselected write does nothing.
    actRTC = 1'b0;
    dir = 8'd1;
    out_port = 8'h66;
    writestrobe = 1'b1;
    @(negedge clk);
    writestrobe = 1'b0;
    mon(6, 8'h00, 8'h00, 1'b0);
    chk("nosel_busy", m_busy, 0);
    chk("nosel_cs", m_cs, 0);

    // Minimum timing instance: 6-clock cycle, 1-clock strobes.
    wr(1, 2'd0, 8'h11);
    wr(1, 2'd1, 8'h22);
    b2 = 0; a2n = 0; d2n = 0; a2i = -1; d2i = -1; a2v = 8'h00; d2v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (busy2) b2++;
      if (!rtc_rd_n2) b2 = b2 + 100;
      if (!rtc_wr_n2 && rtc_ad_sel2) begin a2n++; a2i = i; a2v = rtc_ad_out2; end
      if (!rtc_wr_n2 && !rtc_ad_sel2) begin d2n++; d2i = i; d2v = rtc_ad_out2; end
      @(negedge clk);
    end
    chk("min_busy_cycles", b2, 6);
    chk("min_addr_strobe", {a2n[7:0], a2i[7:0], a2v}, {8'd1, 8'd1, 8'h11});
    chk("min_data_strobe", {d2n[7:0], d2i[7:0], d2v}, {8'd1, 8'd4, 8'h22});
    chk("min_idle_pins", {rtc_cs_n2, rtc_ad_oe2}, 2'b10);
    dir = 8'd0;
    @(negedge clk);
    chk("min_addr_back", in_portRTC2, 8'h11);

    // Reset in the third address-strobe cycle.
    wr(0, 2'd0, 8'h21);
    wr(0, 2'd1, 8'h45);
    repeat (4) @(negedge clk);
    chk("rst_mid_strobe_low", rtc_wr_n, 1'b0);
    kcpsm6_reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_pins", {busy, rtc_ad_oe, rtc_cs_n, rtc_ad_sel, rtc_wr_n, rtc_rd_n}, 6'b001111);
    chk("rst_mid_ad_out", rtc_ad_out, 8'h00);
    kcpsm6_reset = 1'b0;
    dir = 8'd0;
    @(negedge clk);
    chk("rst_mid_addr", in_portRTC, 8'h00);
    @(negedge clk);
    chk("rst_mid_stay_idle", {busy, rtc_cs_n}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
